y86_regfile_decode: RTL and testbench

- Decode/write-back register file for the sequential Y86-64 core.
- Produces the operand pair valA/valB that the execute stage consumes.
- Accepts valE from execute and valM from memory, and commits them to the 15 program registers.
- Contains the icode-driven source and destination selection, so decode and write-back are the two ends of the execute interface.

---
 rtl/y86_regfile_decode_if.sv | 20 ++
 rtl/y86_regfile_decode.sv | 64 ++++++
 tb/tb_y86_regfile_decode.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/y86_regfile_decode_if.sv
// y86_regfile_decode_if: decode/write-back bundle between the core and the register file
interface y86_regfile_decode_if #(parameter int WORD_W = 64);
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              cond;
  logic              wb_en;
  logic [WORD_W-1:0] valE;
  logic [WORD_W-1:0] valM;
  logic [WORD_W-1:0] valA;
  logic [WORD_W-1:0] valB;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [3:0]        dstE;
  logic [3:0]        dstM;
  modport master (output icode, rA, rB, cond, wb_en, valE, valM,
                  input  valA, valB, srcA, srcB, dstE, dstM);
  modport slave  (input  icode, rA, rB, cond, wb_en, valE, valM,
                  output valA, valB, srcA, srcB, dstE, dstM);
endinterface

// File: rtl/y86_regfile_decode.sv
// y86_regfile_decode: Y86-64 register file with icode-driven operand/destination decode (optional WRITE_BYPASS_EN)
module y86_regfile_decode #(
  parameter int                WORD_W    = 64,
  parameter logic [WORD_W-1:0] RSP_RESET = '0
) (
  input logic                  clk,
  input logic                  reset,
  y86_regfile_decode_if.slave  bus
);
  logic [WORD_W-1:0] r_regs [15];
  logic [3:0]        w_src_a, w_src_b, w_dst_e, w_dst_m;
  logic [WORD_W-1:0] w_rd_a, w_rd_b;
  // Register IDs selected by instruction class; RNONE (F) when unused
  always_comb begin
    w_src_a = 4'hF;
    w_src_b = 4'hF;
    w_dst_e = 4'hF;
    w_dst_m = 4'hF;
    case (bus.icode)
      4'h2: begin w_src_a = bus.rA; w_dst_e = bus.cond ? bus.rB : 4'hF; end
      4'h3: w_dst_e = bus.rB;
      4'h4: begin w_src_a = bus.rA; w_src_b = bus.rB; end
      4'h5: begin w_src_b = bus.rB; w_dst_m = bus.rA; end
      4'h6: begin w_src_a = bus.rA; w_src_b = bus.rB; w_dst_e = bus.rB; end
      4'h8: begin w_src_b = 4'h4; w_dst_e = 4'h4; end
      4'h9: begin w_src_a = 4'h4; w_src_b = 4'h4; w_dst_e = 4'h4; end
      4'hA: begin w_src_a = bus.rA; w_src_b = 4'h4; w_dst_e = 4'h4; end
      4'hB: begin w_src_a = 4'h4; w_src_b = 4'h4; w_dst_e = 4'h4; w_dst_m = bus.rA; end
      default: ;
    endcase
  end
  // Stored reads; RNONE has no storage and reads as zero
  always_comb begin
    w_rd_a = (w_src_a == 4'hF) ? '0 : r_regs[w_src_a];
    w_rd_b = (w_src_b == 4'hF) ? '0 : r_regs[w_src_b];
  end
  // Write-back: dstM is written last so it wins the popq %rsp collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= (i == 4) ? RSP_RESET : '0;
    end else if (bus.wb_en) begin
      if (w_dst_e != 4'hF) r_regs[w_dst_e] <= bus.valE;
      if (w_dst_m != 4'hF) r_regs[w_dst_m] <= bus.valM;
    end
  end
  assign bus.srcA = w_src_a;
  assign bus.srcB = w_src_b;
  assign bus.dstE = w_dst_e;
  assign bus.dstM = w_dst_m;
`ifdef WRITE_BYPASS_EN
  logic w_byp;
  // Forward this cycle's write data to matching reads, dstM before dstE
  always_comb begin
    w_byp    = bus.wb_en && !reset;
    bus.valA = (w_byp && w_dst_m != 4'hF && w_src_a == w_dst_m) ? bus.valM :
               (w_byp && w_dst_e != 4'hF && w_src_a == w_dst_e) ? bus.valE : w_rd_a;
    bus.valB = (w_byp && w_dst_m != 4'hF && w_src_b == w_dst_m) ? bus.valM :
               (w_byp && w_dst_e != 4'hF && w_src_b == w_dst_e) ? bus.valE : w_rd_b;
  end
`else
  assign bus.valA = w_rd_a;
  assign bus.valB = w_rd_b;
`endif
endmodule

// File: tb/tb_y86_regfile_decode.sv
// tb_y86_regfile_decode: scoreboard bench with a behavioural Y86 register-file model
module tb_y86_regfile_decode;
  localparam logic [63:0] RSP_RST = 64'h100;
  typedef struct {
    logic        rst;
    logic [3:0]  icode, ra, rb;
    logic        cond, wb;
    logic [63:0] ve, vm;
  } vec_t;
  typedef struct {
    logic [3:0]  sa, sb, de, dm;
    logic [63:0] va, vb;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  y86_regfile_decode_if #(.WORD_W(64)) bus();
  y86_regfile_decode #(.WORD_W(64), .RSP_RESET(RSP_RST)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [63:0] model [16];
  bit          model_ok = 1'b0;
  exp_t        sbq [$];
  int          vectors = 0;
  int          miscompares = 0;
  function automatic logic [3:0] f_src_a(vec_t v);
    if (v.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return v.ra;
    if (v.icode inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] f_src_b(vec_t v);
    if (v.icode inside {4'h4, 4'h5, 4'h6}) return v.rb;
    if (v.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] f_dst_e(vec_t v);
    if (v.icode == 4'h2) return v.cond ? v.rb : 4'hF;
    if (v.icode inside {4'h3, 4'h6}) return v.rb;
    if (v.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] f_dst_m(vec_t v);
    return (v.icode inside {4'h5, 4'hB}) ? v.ra : 4'hF;
  endfunction
  function automatic logic [63:0] f_read(vec_t v, logic [3:0] src);
    logic [63:0] r;
    r = model[src];
`ifdef WRITE_BYPASS_EN
    if (v.wb && !v.rst) begin
      if (src != 4'hF && src == f_dst_m(v)) r = v.vm;
      else if (src != 4'hF && src == f_dst_e(v)) r = v.ve;
    end
`endif
    return r;
  endfunction
  task automatic apply(input vec_t v);
    exp_t e;
    reset     = v.rst;
    bus.icode = v.icode;
    bus.rA    = v.ra;
    bus.rB    = v.rb;
    bus.cond  = v.cond;
    bus.wb_en = v.wb;
    bus.valE  = v.ve;
    bus.valM  = v.vm;
    e.sa = f_src_a(v);
    e.sb = f_src_b(v);
    e.de = f_dst_e(v);
    e.dm = f_dst_m(v);
    e.va = f_read(v, e.sa);
    e.vb = f_read(v, e.sb);
    if (model_ok) sbq.push_back(e);
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < 16; i++) model[i] = (i == 4) ? RSP_RST : 64'h0;
      model_ok = 1'b1;
    end else if (v.wb) begin
      if (e.de != 4'hF) model[e.de] = v.ve;
      if (e.dm != 4'hF) model[e.dm] = v.vm;
    end
    #1;
  endtask
  function automatic vec_t mk(logic rst, logic [3:0] ic, logic [3:0] ra, logic [3:0] rb,
                              logic cond, logic wb, logic [63:0] ve, logic [63:0] vm);
    vec_t v;
    v.rst = rst; v.icode = ic; v.ra = ra; v.rb = rb;
    v.cond = cond; v.wb = wb; v.ve = ve; v.vm = vm;
    return v;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      vectors++;
      chk("srcA", {60'h0, bus.srcA}, {60'h0, e.sa});
      chk("srcB", {60'h0, bus.srcB}, {60'h0, e.sb});
      chk("dstE", {60'h0, bus.dstE}, {60'h0, e.de});
      chk("dstM", {60'h0, bus.dstM}, {60'h0, e.dm});
      chk("valA", bus.valA, e.va);
      chk("valB", bus.valB, e.vb);
    end
  end
  initial begin
    vec_t v;
    @(posedge clk); #1;
    apply(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0, 64'h0));
    apply(mk(0, 4'hA, 4'h0, 4'hF, 0, 0, 64'h0, 64'h0));
    apply(mk(0, 4'h3, 4'hF, 4'h2, 0, 1, 64'h5, 64'h0));
    apply(mk(0, 4'h6, 4'h2, 4'h2, 0, 0, 64'h0, 64'h0));
    apply(mk(0, 4'h2, 4'h2, 4'h3, 0, 1, 64'h7, 64'h0));
    apply(mk(0, 4'h6, 4'h3, 4'h3, 0, 0, 64'h0, 64'h0));
    apply(mk(0, 4'h2, 4'h2, 4'h3, 1, 1, 64'h7, 64'h0));
    apply(mk(0, 4'h6, 4'h3, 4'h3, 0, 0, 64'h0, 64'h0));
    apply(mk(0, 4'hB, 4'h4, 4'hF, 0, 1, 64'h108, 64'hDEAD));
    apply(mk(0, 4'h9, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0));
    apply(mk(0, 4'h3, 4'hF, 4'h1, 0, 0, 64'h9, 64'h0));
    apply(mk(0, 4'h4, 4'h1, 4'h1, 0, 0, 64'h0, 64'h0));
    apply(mk(0, 4'h0, 4'h3, 4'h4, 1, 1, 64'h11, 64'h22));
    apply(mk(0, 4'h3, 4'hF, 4'h1, 0, 1, 64'h9, 64'h0));
    apply(mk(1, 4'h3, 4'hF, 4'h1, 0, 1, 64'h77, 64'h0));
    apply(mk(0, 4'h4, 4'h1, 4'h4, 0, 0, 64'h0, 64'h0));
    apply(mk(0, 4'h3, 4'hF, 4'h2, 0, 1, 64'h33, 64'h0));
    apply(mk(0, 4'h6, 4'h2, 4'h5, 0, 1, 64'h2A, 64'h0));
    apply(mk(0, 4'h6, 4'h2, 4'h5, 0, 0, 64'h0, 64'h0));
    apply(mk(0, 4'h5, 4'hE, 4'hF, 0, 1, 64'h0, 64'h5A5A));
    apply(mk(0, 4'h4, 4'hE, 4'hF, 0, 0, 64'h0, 64'h0));
    for (int n = 0; n < 600; n++) begin
      v.rst   = ($urandom_range(0, 40) == 0);
      v.icode = 4'($urandom_range(0, 15));
      v.ra    = 4'($urandom_range(0, 15));
      v.rb    = 4'($urandom_range(0, 15));
      v.cond  = 1'($urandom_range(0, 1));
      v.wb    = ($urandom_range(0, 3) != 0);
      v.ve    = {$urandom, $urandom};
      v.vm    = {$urandom, $urandom};
      apply(v);
    end
    repeat (2) @(posedge clk);
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
